fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 148 ++++++++++++++
 tb/tb_fetch_stage.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch and IF/ID producer with interrupt entry and
//               return. Optional FETCH_IRQ_CNT_EN adds a saturating take count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] ISR_VEC  = 32'h0000_0100,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_mem,
  input  logic        hazard,
  input  logic        flush,
  input  logic [31:0] branch_target,
  input  logic        rti_ex,
  input  logic        interrupt_branch_alert,
  input  logic        irq,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] curr_pc,
  output logic [31:0] next_pc,
  output logic        in_isr,
  output logic [31:0] epc
`ifdef FETCH_IRQ_CNT_EN
  ,
  output logic [15:0] irq_count
`endif
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ISR  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_take;
  logic        w_rti;
  logic [31:0] r_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] r_instruction;
  logic [31:0] r_curr_pc;
  logic [31:0] r_next_pc;
  logic [31:0] r_epc;
  logic        r_alert_d;
  logic        r_irq_pending;

  assign w_pc_plus4 = r_pc + 32'd4;

  // Interrupts wait until no control transfer sits in ID (alert) or EX (alert_d).
  always_comb begin
    w_state_nxt = r_state;
    w_take = (r_state == S_IDLE) && r_irq_pending && !interrupt_branch_alert &&
             !r_alert_d && !stall_mem && !flush && !hazard;
    w_rti  = (r_state == S_ISR) && rti_ex && !stall_mem && !flush;
    if (w_take) begin
      w_state_nxt = S_ISR;
    end else if (w_rti) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_alert_d     <= 1'b0;
      r_irq_pending <= 1'b0;
    end else begin
      r_alert_d <= interrupt_branch_alert;
      if (irq) begin
        r_irq_pending <= 1'b1;
      end else if (w_take) begin
        r_irq_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_instruction <= NOP_INST;
      r_curr_pc     <= 32'd0;
      r_next_pc     <= 32'd0;
      r_epc         <= 32'd0;
    end else if (!stall_mem) begin
      if (flush) begin
        r_pc          <= branch_target;
        r_instruction <= NOP_INST;
        r_curr_pc     <= 32'd0;
        r_next_pc     <= 32'd0;
      end else if (w_rti) begin
        r_pc          <= r_epc;
        r_instruction <= NOP_INST;
        r_curr_pc     <= 32'd0;
        r_next_pc     <= 32'd0;
      end else if (w_take) begin
        // The instruction at r_pc is abandoned and replayed after return.
        r_epc         <= r_pc;
        r_pc          <= ISR_VEC;
        r_instruction <= NOP_INST;
        r_curr_pc     <= 32'd0;
        r_next_pc     <= 32'd0;
      end else if (!hazard) begin
        r_pc          <= w_pc_plus4;
        r_instruction <= imem_rdata;
        r_curr_pc     <= r_pc;
        r_next_pc     <= w_pc_plus4;
      end
    end
  end

`ifdef FETCH_IRQ_CNT_EN
  logic [15:0] r_irq_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_irq_count <= 16'd0;
    end else if (w_take && (r_irq_count != 16'hFFFF)) begin
      r_irq_count <= r_irq_count + 16'd1;
    end
  end

  assign irq_count = r_irq_count;
`endif

  assign imem_addr   = r_pc;
  assign instruction = r_instruction;
  assign curr_pc     = r_curr_pc;
  assign next_pc     = r_next_pc;
  assign epc         = r_epc;
  assign in_isr      = (r_state == S_ISR);

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed self-checking bench for fetch_stage with a fetch
//               scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  localparam logic [31:0] C_NOP = 32'h0000_0013;
  localparam logic [31:0] C_ISR = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic        stall_mem;
  logic        hazard;
  logic        flush;
  logic [31:0] branch_target;
  logic        rti_ex;
  logic        interrupt_branch_alert;
  logic        irq;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] curr_pc;
  logic [31:0] next_pc;
  logic        in_isr;
  logic [31:0] epc;
`ifdef FETCH_IRQ_CNT_EN
  logic [15:0] irq_count;
`endif

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] cpc;
    logic [31:0] npc;
  } fetch_exp_t;

  fetch_exp_t  sb[$];
  int          checks;
  int          failures;
  logic [31:0] exp_pc;
  int          exp_cnt;

  fetch_stage dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .stall_mem              (stall_mem),
    .hazard                 (hazard),
    .flush                  (flush),
    .branch_target          (branch_target),
    .rti_ex                 (rti_ex),
    .interrupt_branch_alert (interrupt_branch_alert),
    .irq                    (irq),
    .imem_addr              (imem_addr),
    .imem_rdata             (imem_rdata),
    .instruction            (instruction),
    .curr_pc                (curr_pc),
    .next_pc                (next_pc),
    .in_isr                 (in_isr),
    .epc                    (epc)
`ifdef FETCH_IRQ_CNT_EN
    ,
    .irq_count              (irq_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Normal fetch: the expected IF/ID triple is queued as the word is driven
  // and popped once the edge has registered it.
  task automatic fetch(input logic [31:0] data);
    fetch_exp_t e;
    fetch_exp_t g;
    imem_rdata = data;
    e.ins = data;
    e.cpc = exp_pc;
    e.npc = exp_pc + 32'd4;
    sb.push_back(e);
    exp_pc = exp_pc + 32'd4;
    step();
    g = sb.pop_front();
    chk("fetch_instruction", instruction, g.ins);
    chk("fetch_curr_pc", curr_pc, g.cpc);
    chk("fetch_next_pc", next_pc, g.npc);
    chk("fetch_imem_addr", imem_addr, exp_pc);
  endtask

  task automatic take_check(input string tag);
    chk({tag, "_epc"}, epc, exp_pc);
    exp_pc = C_ISR;
    exp_cnt++;
    chk({tag, "_pc"}, imem_addr, C_ISR);
    chk({tag, "_in_isr"}, {31'd0, in_isr}, 32'd1);
    chk({tag, "_nop"}, instruction, C_NOP);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_cnt = 0;
    rst_n = 1'b0;
    stall_mem = 1'b0;
    hazard = 1'b0;
    flush = 1'b0;
    branch_target = 32'd0;
    rti_ex = 1'b0;
    interrupt_branch_alert = 1'b0;
    irq = 1'b0;
    imem_rdata = 32'd0;

    step();
    step();
    chk("rst_pc", imem_addr, 32'd0);
    chk("rst_instruction", instruction, C_NOP);
    chk("rst_curr_pc", curr_pc, 32'd0);
    chk("rst_next_pc", next_pc, 32'd0);
    chk("rst_in_isr", {31'd0, in_isr}, 32'd0);
    chk("rst_epc", epc, 32'd0);
    rst_n = 1'b1;
    exp_pc = 32'd0;

    fetch(32'hAAAA_0001);
    fetch(32'hBBBB_0002);
    fetch(32'hCCCC_0003);

    // Hazard holds PC and IF/ID.
    hazard = 1'b1;
    imem_rdata = 32'hDDDD_0004;
    step();
    step();
    chk("hazard_pc", imem_addr, 32'd12);
    chk("hazard_instruction", instruction, 32'hCCCC_0003);
    chk("hazard_curr_pc", curr_pc, 32'd8);
    hazard = 1'b0;

    flush = 1'b1;
    branch_target = 32'h40;
    step();
    flush = 1'b0;
    chk("flush_instruction", instruction, C_NOP);
    chk("flush_curr_pc", curr_pc, 32'd0);
    chk("flush_pc", imem_addr, 32'h40);
    exp_pc = 32'h40;
    fetch(32'hEEEE_0005);

    // irq deferred while a control transfer is in ID, then in EX.
    interrupt_branch_alert = 1'b1;
    irq = 1'b1;
    fetch(32'h1111_0006);
    irq = 1'b0;
    fetch(32'h1111_0007);
    interrupt_branch_alert = 1'b0;
    fetch(32'h1111_0008);
    chk("defer_in_isr", {31'd0, in_isr}, 32'd0);
    step();
    take_check("take1");

    // irq inside ISR stays pending, taken right after return.
    irq = 1'b1;
    fetch(32'h2222_0009);
    irq = 1'b0;
    rti_ex = 1'b1;
    step();
    rti_ex = 1'b0;
    chk("rti_pc", imem_addr, 32'h50);
    chk("rti_in_isr", {31'd0, in_isr}, 32'd0);
    chk("rti_nop", instruction, C_NOP);
    exp_pc = 32'h50;
    step();
    take_check("take2");

    // flush beats rti_ex, and rti_ex does not re-fire once dropped.
    flush = 1'b1;
    rti_ex = 1'b1;
    branch_target = 32'h200;
    step();
    flush = 1'b0;
    rti_ex = 1'b0;
    chk("flush_rti_pc", imem_addr, 32'h200);
    chk("flush_rti_in_isr", {31'd0, in_isr}, 32'd1);
    exp_pc = 32'h200;
    fetch(32'h3333_000A);
    chk("still_isr", {31'd0, in_isr}, 32'd1);
    rti_ex = 1'b1;
    step();
    rti_ex = 1'b0;
    chk("rti2_pc", imem_addr, 32'h50);
    chk("rti2_in_isr", {31'd0, in_isr}, 32'd0);
    exp_pc = 32'h50;

    // stall freezes everything but irq_pending; flush then take follow.
    fetch(32'h4444_000B);
    stall_mem = 1'b1;
    flush = 1'b1;
    branch_target = 32'h80;
    irq = 1'b1;
    step();
    chk("stall_pc", imem_addr, 32'h54);
    chk("stall_instruction", instruction, 32'h4444_000B);
    chk("stall_curr_pc", curr_pc, 32'h50);
    chk("stall_in_isr", {31'd0, in_isr}, 32'd0);
    stall_mem = 1'b0;
    irq = 1'b0;
    step();
    flush = 1'b0;
    chk("post_stall_flush_pc", imem_addr, 32'h80);
    chk("post_stall_flush_nop", instruction, C_NOP);
    chk("post_stall_in_isr", {31'd0, in_isr}, 32'd0);
    exp_pc = 32'h80;
    step();
    take_check("take3");

    rti_ex = 1'b1;
    step();
    chk("rti3_pc", imem_addr, 32'h80);
    exp_pc = 32'h80;
    // rti_ex held into IDLE is ignored: plain fetch.
    fetch(32'h5555_000C);
    rti_ex = 1'b0;
    chk("rti_idle_in_isr", {31'd0, in_isr}, 32'd0);

    // PC wraps modulo 2^32.
    flush = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    step();
    flush = 1'b0;
    exp_pc = 32'hFFFF_FFFC;
    fetch(32'h6666_000D);
    chk("wrap_pc", imem_addr, 32'd0);

    // Reset in ISR with an irq pending drops both.
    irq = 1'b1;
    fetch(32'h7777_000E);
    irq = 1'b0;
    step();
    take_check("take4");
    irq = 1'b1;
    step();
    irq = 1'b0;
`ifdef FETCH_IRQ_CNT_EN
    chk("irq_count", {16'd0, irq_count}, exp_cnt);
`endif
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst2_in_isr", {31'd0, in_isr}, 32'd0);
    chk("rst2_pc", imem_addr, 32'd0);
    chk("rst2_epc", epc, 32'd0);
`ifdef FETCH_IRQ_CNT_EN
    chk("rst2_irq_count", {16'd0, irq_count}, 32'd0);
`endif
    exp_pc = 32'd0;
    fetch(32'h8888_000F);
    chk("no_pending_after_rst", {31'd0, in_isr}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
